maj_chain_eval: RTL and testbench
=================================

// Module: maj_chain_eval
// PURPOSE
// - Programmable, sequential evaluator for 7-input-class Boolean functions built as chains of 3-input majority (MAJ3) nodes.
// - Holds a per-node operand table and evaluates one node per clock over a latched input vector.
// - Result is the value of the last active node.
// - Replaces hard-wired majority-chain netlists, so one instance can be retargeted to any chained MAJ3 function by reprogramming.
// PARAMETERS
// - N_IN      7   number of primary inputs x[N_IN-1:0]
// - MAX_NODES 8   depth of the node table (max chain length)
// - SEL_W     $clog2(1+N_IN+MAX_NODES) (=4)   operand select width
// - Derived:
//   - CFG_W = 3*(SEL_W+1) (=15)
//   - AW = $clog2(MAX_NODES) (=3)
//   - NW = $clog2(MAX_NODES+1) (=4)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - cfg_we     in   1      node-table write strobe
// - cfg_addr   in   AW     node index to write
// - cfg_data   in   CFG_W  {inv_c,sel_c,inv_b,sel_b,inv_a,sel_a}, LSB = sel_a[0]
// - cfg_ready  out  1      1 when in IDLE; writes are honoured only then
// - in_valid   in   1      input vector offered
// - in_ready   out  1      1 in IDLE; accept on in_valid & in_ready
// - x          in   N_IN   input vector, x[i] = input i
// - num_nodes  in   NW     active chain length, sampled at accept
// - out_valid  out  1      result valid; held until out_ready
// - out_ready  in   1      consumer accepts result
// - out        out  1      value of node num_nodes-1
// - out_err    out  1      config fault flag, qualified by out_valid
// BEHAVIOUR
// - Operand select decode:
//   - sel = 0: constant 0
//   - sel = 1..N_IN: x[sel-1]
//   - sel = N_IN+1+j: node result w[j]
//   - Any other value reads 0 and sets the error bit.
//   - inv_* XORs the selected operand, so a const-0 select with inv = 1 gives const 1.
// - Node function: w[k] = MAJ(a,b,c) = ab | ac | bc (after inversion).
//   - AND = MAJ(0,a,b); OR = MAJ(1,a,b).
// - Legal references: node k may reference only w[j] with j < k.
//   - A reference with j >= k reads 0 and sets the error bit.
// - FSM IDLE -> EVAL -> DONE -> IDLE:
//   - IDLE: in_ready = cfg_ready = 1. On accept, latch x and num_nodes, set idx = 0, clear the error bit, go to EVAL.
//   - EVAL: each cycle compute w[idx] from the table and store it. idx++. After storing node n-1, go to DONE.
//   - DONE: out_valid = 1, out = w[n-1], with out and out_err stable. On out_ready, go to IDLE (out_valid = 0 the next cycle).
// - Latency:
//   - out_valid rises exactly n clock edges after the accept edge, where n = effective num_nodes.
//   - Throughput is one result per n+2 cycles (no overlap).
// - num_nodes = 0: skip EVAL; out = 0, out_err = 1, out_valid one edge after accept.
// - num_nodes > MAX_NODES: clamp n to MAX_NODES and set out_err = 1.
// - Config writes:
//   - cfg_we outside IDLE is ignored; cfg_addr >= MAX_NODES is ignored.
//   - cfg_we together with an accept in the same IDLE cycle: the write lands on that edge and the evaluation uses the new entry.
// - Reset (async, any state):
//   - state = IDLE, out_valid = 0, out = 0, out_err = 0, idx = 0.
//   - All table entries are cleared to 0, so every node computes MAJ(0,0,0) = 0.
//   - in_ready = cfg_ready = 1 once rst_n deasserts.
//   - Reset mid-EVAL/DONE drops the in-flight result.
// - out, out_err are registered; no combinational path from inputs to outputs except in_ready/cfg_ready from state.
// TESTING
// - Program the 5-node chain, then run two vectors with num_nodes = 5:
//   - Table:
//     - w0 = MAJ(x1,x2,x3)
//     - w1 = MAJ(x2,x4,w0)
//     - w2 = MAJ(x1,x6,w1)
//     - w3 = MAJ(x4,x5,w2)
//     - w4 = MAJ(x0,w0,w3)
//   - x = 7'b0000111 -> out = 1, out_err = 0, out_valid 5 edges after accept.
//   - x = 7'b0000001 -> out = 0.
// - Exhaustive: same table, all 128 x vectors -> out matches a bench MAJ3-chain model; also x = 0 -> 0 and x = 7'h7F -> 1.
// - Inversion/constants: node0 = MAJ(~0,x0,0), num_nodes = 1:
//   - x0 = 1 -> out = 1 one edge after accept.
//   - node0 = MAJ(~0,~x0,0) with x0 = 1 -> out = 0.
// - Error cases, each -> out_err = 1:
//   - node1 selects w1 (self-reference), num_nodes = 2.
//   - num_nodes = 0 -> out = 0.
//   - num_nodes = 12 -> clamped to 8 evaluations.
// - Handshake:
//   - Hold out_ready = 0 for 10 cycles in DONE -> out and out_valid stable; in_ready = 0; cfg_we during this time is ignored (table readback via a later eval unchanged).
//   - The same-cycle cfg_we + accept case uses the new entry.
// - Reset: assert rst_n = 0 mid-EVAL -> out_valid = 0, in_ready = 1 after release; the next eval without reprogramming returns out = 0.

Source files
------------

// File: rtl/maj_chain_eval.sv
// ============================================================================
// maj_chain_eval : programmable sequential evaluator for chained MAJ3 networks
// Revision 1.0
// ============================================================================
`default_nettype none

module maj_chain_eval #(
    parameter int N_IN      = 7,
    parameter int MAX_NODES = 8,
    parameter int SEL_W     = $clog2(1 + N_IN + MAX_NODES),
    parameter int CFG_W     = 3 * (SEL_W + 1),
    parameter int AW        = $clog2(MAX_NODES),
    parameter int NW        = $clog2(MAX_NODES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  x,
    input  logic [NW-1:0]    num_nodes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    logic [CFG_W-1:0]     tab [MAX_NODES];
    logic [N_IN-1:0]      x_lat;
    logic [NW-1:0]        n_lat;
    logic [AW-1:0]        idx;
    logic                 err_acc;
    logic [MAX_NODES-1:0] w;

    logic                 accept;
    logic                 wr_en;
    logic                 clamp;
    logic [NW-1:0]        eff_n;
    logic                 last;
    logic [CFG_W-1:0]     entry;
    logic [2:0]           ops;
    logic                 node_err;
    logic [SEL_W-1:0]     sel;
    logic                 hit;
    logic                 maj;

    assign in_ready  = (state == S_IDLE);
    assign cfg_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign accept = in_valid && (state == S_IDLE);
    assign wr_en  = cfg_we && (state == S_IDLE) && (32'(cfg_addr) < MAX_NODES);
    assign clamp  = (num_nodes > NW'(MAX_NODES));
    assign eff_n  = clamp ? NW'(MAX_NODES) : num_nodes;
    assign last   = ((NW'(idx) + NW'(1)) == n_lat);
    assign entry  = tab[idx];

    // Operand decode: only strictly earlier node results are legal references;
    // anything unmatched reads 0 and flags a configuration fault.
    always_comb begin
        ops      = 3'b000;
        node_err = 1'b0;
        sel      = '0;
        hit      = 1'b0;
        for (int o = 0; o < 3; o++) begin
            sel = entry[o*(SEL_W+1) +: SEL_W];
            hit = (sel == '0);
            for (int i = 0; i < N_IN; i++) begin
                if (int'(sel) == i + 1) begin
                    ops[o] = x_lat[i];
                    hit    = 1'b1;
                end
            end
            for (int j = 0; j < MAX_NODES; j++) begin
                if ((int'(sel) == N_IN + 1 + j) && (j < int'(idx))) begin
                    ops[o] = w[j];
                    hit    = 1'b1;
                end
            end
            if (!hit) begin
                node_err = 1'b1;
            end
            ops[o] = ops[o] ^ entry[o*(SEL_W+1) + SEL_W];
        end
    end

    assign maj = (ops[0] & ops[1]) | (ops[0] & ops[2]) | (ops[1] & ops[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (in_valid) state_d = S_EVAL;
            S_EVAL: if ((n_lat == '0) || last) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat   <= '0;
            n_lat   <= '0;
            idx     <= '0;
            err_acc <= 1'b0;
            w       <= '0;
            out     <= 1'b0;
            out_err <= 1'b0;
            for (int k = 0; k < MAX_NODES; k++) begin
                tab[k] <= '0;
            end
        end else begin
            // A write in the accept cycle lands before the first node is read.
            if (wr_en) begin
                tab[cfg_addr] <= cfg_data;
            end
            if (accept) begin
                x_lat   <= x;
                n_lat   <= eff_n;
                idx     <= '0;
                err_acc <= clamp;
            end
            if (state == S_EVAL) begin
                if (n_lat == '0) begin
                    out     <= 1'b0;
                    out_err <= 1'b1;
                end else begin
                    w[idx]  <= maj;
                    idx     <= idx + AW'(1);
                    err_acc <= err_acc | node_err;
                    if (last) begin
                        out     <= maj;
                        out_err <= err_acc | node_err;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maj_chain_eval.sv
// Self-checking bench for maj_chain_eval against a count-of-ones MAJ3-chain model.
`default_nettype none

module tb_maj_chain_eval;

    localparam int N_IN = 7;
    localparam int MAXN = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic        cfg_ready;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  x = '0;
    logic [3:0]  num_nodes = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [14:0] tab_m [MAXN];

    always #5 clk = ~clk;

    maj_chain_eval dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .num_nodes(num_nodes), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] mk(input int sa, input bit ia, input int sb,
                                       input bit ib, input int sc, input bit ic);
        return {ic, 4'(sc), ib, 4'(sb), ia, 4'(sa)};
    endfunction

    // Returns {err, out}: each node output is 1 when at least two operands are 1.
    function automatic logic [1:0] model(input logic [6:0] xv, input int n);
        logic [MAXN-1:0] wv;
        logic err;
        int ne, s, ones;
        logic v;
        wv = '0;
        err = 1'b0;
        ne = n;
        if (n == 0) return 2'b10;
        if (n > MAXN) begin
            ne = MAXN;
            err = 1'b1;
        end
        for (int k = 0; k < ne; k++) begin
            ones = 0;
            for (int o = 0; o < 3; o++) begin
                s = int'(tab_m[k][o*5 +: 4]);
                v = 1'b0;
                if (s == 0) v = 1'b0;
                else if (s <= N_IN) v = xv[s-1];
                else if (s - N_IN - 1 < k) v = wv[s-N_IN-1];
                else err = 1'b1;
                v = v ^ tab_m[k][o*5 + 4];
                ones += int'(v);
            end
            wv[k] = (ones >= 2);
        end
        return {err, wv[ne-1]};
    endfunction

    task automatic write_cfg(input int a, input logic [14:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tab_m[a] = d;
    endtask

    task automatic accept(input logic [6:0] xv, input int n, input bit wr,
                          input int wa, input logic [14:0] wd);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; x = xv; num_nodes = 4'(n);
        cfg_we = wr; cfg_addr = 3'(wa); cfg_data = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        if (wr) tab_m[wa] = wd;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout", 0, 1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
    endtask

    task automatic eval_chk(input string tag, input logic [6:0] xv, input int n,
                            input bit wr, input int wa, input logic [14:0] wd,
                            output logic o, output logic e);
        int lat;
        logic [1:0] exp;
        accept(xv, n, wr, wa, wd);
        exp = model(xv, n);
        wait_done(lat);
        o = out; e = out_err;
        check({tag, "_out"}, out, exp[0]);
        check({tag, "_err"}, out_err, exp[1]);
        check({tag, "_lat"}, lat, (n == 0) ? 1 : ((n > MAXN) ? MAXN : n));
        release_out();
    endtask

    initial begin
        logic o, e;
        logic [14:0] d;
        int lat;
        for (int k = 0; k < MAXN; k++) tab_m[k] = '0;

        #23;
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_err", out_err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);

        // Five-node chain; selects: x_i -> i+1, w_j -> 8+j.
        write_cfg(0, mk(2, 0, 3, 0, 4, 0));
        write_cfg(1, mk(3, 0, 5, 0, 8, 0));
        write_cfg(2, mk(2, 0, 7, 0, 9, 0));
        write_cfg(3, mk(5, 0, 6, 0, 10, 0));
        write_cfg(4, mk(1, 0, 8, 0, 11, 0));
        eval_chk("chain7", 7'b0000111, 5, 0, 0, '0, o, e);
        check("chain7_lit", {e, o}, 2'b01);
        eval_chk("chain1", 7'b0000001, 5, 0, 0, '0, o, e);
        check("chain1_lit", o, 0);

        // Stall in DONE; writes attempted meanwhile must not land.
        accept(7'b0000111, 5, 0, 0, '0);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 3'(i % 8); cfg_data = 15'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_out", out, 1);
            check("hold_err", out_err, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_cfg_ready", cfg_ready, 0);
        end
        cfg_we = 1'b0;
        release_out();

        for (int v = 0; v < 128; v++) eval_chk("exh", 7'(v), 5, 0, 0, '0, o, e);
        eval_chk("x00", 7'h00, 5, 0, 0, '0, o, e);
        check("x00_lit", o, 0);
        eval_chk("x7f", 7'h7F, 5, 0, 0, '0, o, e);
        check("x7f_lit", o, 1);

        write_cfg(0, mk(0, 1, 1, 0, 0, 0));
        eval_chk("inv1", 7'b0000001, 1, 0, 0, '0, o, e);
        check("inv1_lit", {e, o}, 2'b01);
        write_cfg(0, mk(0, 1, 1, 1, 0, 0));
        eval_chk("inv0", 7'b0000001, 1, 0, 0, '0, o, e);
        check("inv0_lit", {e, o}, 2'b00);

        write_cfg(1, mk(9, 0, 1, 0, 2, 0));
        eval_chk("selfref", 7'h7F, 2, 0, 0, '0, o, e);
        check("selfref_lit", e, 1);
        eval_chk("n0", 7'h7F, 0, 0, 0, '0, o, e);
        check("n0_lit", {e, o}, 2'b10);
        eval_chk("n12", 7'h55, 12, 0, 0, '0, o, e);
        check("n12_lit", e, 1);

        // Write coinciding with accept must be seen by the evaluation.
        write_cfg(0, mk(0, 0, 0, 0, 0, 0));
        eval_chk("samecyc", 7'h01, 1, 1, 0, mk(0, 1, 1, 0, 0, 0), o, e);
        check("samecyc_lit", o, 1);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < MAXN; k++) begin
                d = 15'($urandom);
                // Bias operands towards legal references so most runs are fault-free.
                for (int op = 0; op < 3; op++)
                    if ($urandom_range(0, 3) != 0)
                        d[op*5 +: 4] = 4'($urandom_range(0, N_IN + k));
                write_cfg(k, d);
            end
            eval_chk("rand", 7'($urandom), $urandom_range(0, 12), 0, 0, '0, o, e);
        end

        // Reset in the middle of an evaluation.
        accept(7'h7F, 8, 0, 0, '0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        for (int k = 0; k < MAXN; k++) tab_m[k] = '0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        eval_chk("post_rst", 7'h7F, 5, 0, 0, '0, o, e);
        check("post_rst_lit", {e, o}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
